fetch_line_buffer: RTL and testbench
====================================

Name: fetch_line_buffer

Overview:
- Parametrised instruction-fetch front end that succeeds the single-line fetch/IF_ID pair.
- Issues in-order line requests to instruction memory and buffers up to DEPTH returned lines of LINE_WORDS instructions each.
- Delivers one instruction per cycle with its PC and PC+4 to the IF/ID boundary under a valid/ready handshake.
- On a branch flush it discards buffered lines and in-flight responses, then restarts at the branch target, including a mid-line start word.

Parameters:
- WORD_W, 32, instruction width in bits
- LINE_WORDS, 4, instructions per memory line; power of 2, at least 2
- DEPTH, 4, line-buffer capacity in lines; power of 2, at least 2
- ADDR_W, 32, PC width; byte addresses, word aligned
- RESET_PC, 0, fetch start address after reset

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- req_valid  out  1  line request valid
- req_addr  out  ADDR_W  line-aligned request address
- req_ready  in  1  memory accepts the request this cycle
- resp_valid  in  1  line response valid; in order, one per accepted request; no backpressure
- resp_data  in  WORD_W*LINE_WORDS  line data; word 0 in the LSBs
- flush  in  1  branch taken (PCSrc)
- flush_pc  in  ADDR_W  branch target
- instr_valid  out  1  instruction available
- instr_ready  in  1  consumer accepts; low means stall
- instr  out  WORD_W  instruction
- instr_pc  out  ADDR_W  PC of instr
- npc  out  ADDR_W  instr_pc+4, modulo 2^ADDR_W

Behaviour:
- Reset, taking priority over everything:
  - Buffer empty; outstanding=0; drop_cnt=0.
  - req_addr = RESET_PC with the line-offset bits cleared; start_off = RESET_PC word offset.
  - req_valid=0, instr_valid=0, instr/instr_pc/npc=0.
  - A reset mid-operation clears everything the same way; responses for pre-reset requests still arriving after reset are the memory's responsibility (memory is reset together).
- Requests:
  - req_valid=1 when (buffered + outstanding) < DEPTH, not rst, not flush.
  - On req_valid && req_ready: outstanding += 1 and req_addr += LINE_WORDS*4, wrapping at 2^ADDR_W.
- Responses:
  - While drop_cnt>0, each resp_valid decrements drop_cnt and writes nothing.
  - Otherwise the line and its address are written at the tail.
  - Each response decrements outstanding.
  - A push and a pop in the same cycle are legal when the buffer is full.
- Latency: a response written in cycle N gives instr_valid=1 in N+1 at the earliest. There is no bypass.
- Output:
  - Head line, word ptr. instr_pc = line_addr + 4*ptr.
  - When instr_valid=0, all data outputs are 0.
  - instr_valid && instr_ready advances ptr. When ptr==LINE_WORDS-1 the line pops and ptr resets to 0.
  - The first line after reset or flush starts at ptr=start_off; later lines start at 0.
  - With instr_ready low, the outputs hold stable.
- Flush:
  - Flush beats any pop or request in the same cycle; the consumer squashes that word.
  - Buffer is emptied; ptr cleared.
  - drop_cnt = outstanding - (resp_valid ? 1 : 0), plus any existing drop_cnt already pending.
  - req_addr = flush_pc line-aligned; start_off = flush_pc word offset.
  - req_valid=0 in the flush cycle; requests resume the next cycle.
- Back-to-back flushes: each one restarts from its own target; drop counts accumulate.
- Invariant: buffered + outstanding <= DEPTH at all times. Overflow is impossible by credit; an assertion in the bench checks it.

Decomposition:
- Shared package fetch_pkg holds:
  - WORD_BYTES=4
  - line-offset width and word-offset width constants
  - functions line_align(addr) and word_off(addr)
- Natural sub-module: line_fifo, a synchronous DEPTH x (WORD_W*LINE_WORDS + ADDR_W) FIFO with push, pop, clear, count, and full/empty flags.
- Request credit logic, drop counter and word pointer stay in fetch_line_buffer.

Test Plan:
- Reset release, req_ready=1, memory responds 2 cycles later with line 0 = {D,C,B,A} -> req_addr 0x00, 0x10, 0x20, 0x30. Outputs A/pc 0x00/npc 0x04, B/0x04, C/0x08, D/0x0C, then line 1 words, one per cycle with no bubbles.
- Stall: instr_ready held low 5 cycles while showing B at pc 0x04 -> outputs stable. Exactly 4 requests total, then req_valid=0 until a line pops.
- Flush to 0x48 with 2 requests outstanding and no resp_valid that cycle -> next req_addr 0x40. The next 2 responses are discarded. First instr is word 2 of line 0x40 with pc 0x48, npc 0x4C.
- Flush in the same cycle as resp_valid and instr_ready -> the arriving line is not buffered, the pop is ignored, and drop_cnt = outstanding-1.
- rst asserted mid-stream with 3 lines buffered -> next cycle instr_valid=0 and req_addr=RESET_PC. Fetch restarts cleanly from 0x00.
- Wrap: RESET_PC=0xFFFFFFF0, LINE_WORDS=4 -> second req_addr = 0x00000000; the last word has pc 0xFFFFFFFC and npc 0x00000000.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants and address helpers for the fetch front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_OFF_W = 2;   // byte-within-word bits
    localparam int unsigned ADDR_MAX_W = 64;  // widest address the helpers handle

    // Bits needed to select a word inside a line.
    function automatic int unsigned word_off_w(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    // Bits needed to select a byte inside a line.
    function automatic int unsigned line_off_w(input int unsigned line_words);
        return $clog2(line_words) + BYTE_OFF_W;
    endfunction

    // Clear the line-offset bits of a byte address.
    function automatic logic [ADDR_MAX_W-1:0] line_align(input logic [ADDR_MAX_W-1:0] addr,
                                                         input int unsigned          line_words);
        logic [ADDR_MAX_W-1:0] mask;
        mask = ADDR_MAX_W'(line_words * WORD_BYTES) - ADDR_MAX_W'(1);
        return addr & ~mask;
    endfunction

    // Index of the word addressed by a byte address within its line.
    function automatic int unsigned word_off(input logic [ADDR_MAX_W-1:0] addr,
                                             input int unsigned          line_words);
        return 32'((addr >> BYTE_OFF_W) & ADDR_MAX_W'(line_words - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : line_fifo
//  Description : Synchronous FIFO holding fetched lines tagged with address.
//                Push and pop together are allowed when full.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_fifo #(
    parameter int DATA_W = 160,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_i,
    input  logic                      push_i,
    input  logic [DATA_W-1:0]         data_i,
    input  logic                      pop_i,
    output logic [DATA_W-1:0]         data_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      full_o,
    output logic                      empty_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              w_push;
    logic              w_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign w_pop  = pop_i && !empty_o && !clear_i;
    assign w_push = push_i && (!full_o || w_pop) && !clear_i;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (w_push && !w_pop)      count_q <= count_q + CNT_W'(1);
            else if (w_pop && !w_push) count_q <= count_q - CNT_W'(1);
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_push) mem[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_line_buffer
//  Description : Instruction-fetch front end. Issues in-order line requests,
//                buffers returned lines and streams one instruction per cycle
//                with PC / PC+4. Flush discards buffered and in-flight lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_line_buffer
    import fetch_pkg::*;
#(
    parameter int                WORD_W     = 32,
    parameter int                LINE_WORDS = 4,
    parameter int                DEPTH      = 4,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         req_valid,
    output logic [ADDR_W-1:0]            req_addr,
    input  logic                         req_ready,
    input  logic                         resp_valid,
    input  logic [WORD_W*LINE_WORDS-1:0] resp_data,
    input  logic                         flush,
    input  logic [ADDR_W-1:0]            flush_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [WORD_W-1:0]            instr,
    output logic [ADDR_W-1:0]            instr_pc,
    output logic [ADDR_W-1:0]            npc
);

    localparam int OFF_W   = word_off_w(LINE_WORDS);
    localparam int LINE_W  = WORD_W * LINE_WORDS;
    localparam int ENTRY_W = LINE_W + ADDR_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    // Drops can pile up across back-to-back flushes; sized for deep memory pipes.
    localparam int DROP_W  = 16;

    localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(LINE_WORDS * WORD_BYTES);
    localparam logic [ADDR_W-1:0] RESET_LINE = ADDR_W'(line_align(64'(RESET_PC), LINE_WORDS));
    localparam logic [OFF_W-1:0]  RESET_OFF  = OFF_W'(word_off(64'(RESET_PC), LINE_WORDS));
    localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W+1)'(DEPTH);

    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;   // address of next live response
    logic [OFF_W-1:0]  ptr_q, ptr_d;

    logic [CNT_W-1:0]   w_count;
    logic               w_full, w_empty;
    logic [ENTRY_W-1:0] w_head;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [LINE_W-1:0]  w_head_data;
    logic [ADDR_W-1:0]  w_flush_line;
    logic [OFF_W-1:0]   w_flush_off;
    logic               w_credit_ok, w_fire_req, w_live_resp;
    logic               w_push, w_take, w_pop, w_valid;
    logic [ADDR_W-1:0]  w_pc;

    assign w_flush_line = ADDR_W'(line_align(64'(flush_pc), LINE_WORDS));
    assign w_flush_off  = OFF_W'(word_off(64'(flush_pc), LINE_WORDS));

    // Credit counts buffered lines plus live requests still in flight.
    assign w_credit_ok = ((CNT_W+1)'(w_count) + (CNT_W+1)'(outstanding_q)) < DEPTH_C;
    assign req_valid   = !rst && !flush && w_credit_ok;
    assign req_addr    = req_addr_q;
    assign w_fire_req  = req_valid && req_ready;

    assign w_live_resp = resp_valid && (drop_cnt_q == '0);
    assign w_valid     = !rst && !w_empty;
    assign w_take      = w_valid && instr_ready && !flush;
    assign w_pop       = w_take && (ptr_q == OFF_W'(LINE_WORDS - 1));
    assign w_push      = w_live_resp && !flush && (!w_full || w_pop);

    line_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .push_i  (w_push),
        .data_i  ({resp_addr_q, resp_data}),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign w_head_addr = w_head[ENTRY_W-1 -: ADDR_W];
    assign w_head_data = w_head[LINE_W-1:0];
    assign w_pc        = w_head_addr + ADDR_W'({ptr_q, {BYTE_OFF_W{1'b0}}});

    assign instr_valid = w_valid;
    assign instr       = w_valid ? w_head_data[int'(ptr_q)*WORD_W +: WORD_W] : '0;
    assign instr_pc    = w_valid ? w_pc : '0;
    assign npc         = w_valid ? (w_pc + ADDR_W'(WORD_BYTES)) : '0;

    // Next-state for credits, drop counter, addresses and word pointer; flush wins.
    always_comb begin
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        req_addr_d    = req_addr_q;
        resp_addr_d   = resp_addr_q;
        ptr_d         = ptr_q;

        if (w_fire_req) begin
            outstanding_d = outstanding_d + CNT_W'(1);
            req_addr_d    = req_addr_q + LINE_BYTES;
        end
        if (w_live_resp) outstanding_d = outstanding_d - CNT_W'(1);
        if (resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - DROP_W'(1);
        if (w_push) resp_addr_d = resp_addr_q + LINE_BYTES;
        if (w_take) ptr_d = w_pop ? '0 : ptr_q + OFF_W'(1);

        if (flush) begin
            // Everything still in flight becomes a drop; the response arriving now
            // (live or already a drop) is consumed this cycle.
            outstanding_d = '0;
            drop_cnt_d    = drop_cnt_q + DROP_W'(outstanding_q) - DROP_W'(resp_valid);
            req_addr_d    = w_flush_line;
            resp_addr_d   = w_flush_line;
            ptr_d         = w_flush_off;
        end
    end

    // State registers with reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            req_addr_q    <= RESET_LINE;
            resp_addr_q   <= RESET_LINE;
            ptr_q         <= RESET_OFF;
        end else begin
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            req_addr_q    <= req_addr_d;
            resp_addr_q   <= resp_addr_d;
            ptr_q         <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_line_buffer
//  Description : Scoreboard bench for fetch_line_buffer with a fixed-latency
//                line memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_line_buffer;

    localparam int AW = 32;
    localparam int WW = 32;
    localparam int LW = 4;
    localparam int DP = 4;

    logic           clk = 1'b0;
    logic           rst, req_valid, req_ready, resp_valid, flush;
    logic           instr_valid, instr_ready;
    logic [AW-1:0]  req_addr, flush_pc, instr_pc, npc;
    logic [WW*LW-1:0] resp_data;
    logic [WW-1:0]  instr;

    always #5 clk = ~clk;

    fetch_line_buffer #(
        .WORD_W(WW), .LINE_WORDS(LW), .DEPTH(DP), .ADDR_W(AW), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .flush(flush), .flush_pc(flush_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .npc(npc)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; logic [31:0] npc; } exp_t;

    mreq_t       mq[$];
    logic [31:0] reqlog[$];
    exp_t        sb[$];
    int          cyc = 0, mem_lat = 2;
    int          total = 0, bad = 0, n_acc = 0;
    bit          saw_wrap = 1'b0;

    function automatic logic [31:0] f_instr(input logic [31:0] pc);
        return pc ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected instruction stream from a (re)start PC.
    task automatic sb_restart(input logic [31:0] pc);
        exp_t e;
        sb.delete();
        for (int i = 0; i < 48; i++) begin
            e.pc    = 32'(pc + 32'(4 * i));
            e.instr = f_instr(e.pc);
            e.npc   = 32'(e.pc + 32'd4);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Memory: capture accepted requests away from the edge.
    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            reqlog.delete();
        end else if (req_valid && req_ready) begin
            mq.push_back('{addr: req_addr, due: cyc + mem_lat});
            reqlog.push_back(req_addr);
        end
    end

    // Memory: present responses in order once due.
    initial begin
        mreq_t m;
        resp_valid = 1'b0;
        resp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                m = mq.pop_front();
                resp_valid = 1'b1;
                for (int i = 0; i < LW; i++)
                    resp_data[i*WW +: WW] = f_instr(32'(m.addr + 32'(4 * i)));
            end else begin
                resp_valid = 1'b0;
                resp_data  = '0;
            end
        end
    end

    // Monitor: compare each accepted instruction with the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        int   occ;
        if (!rst) begin
            occ = int'(dut.w_count) + int'(dut.outstanding_q);
            total++;
            assert (occ <= DP) else begin
                bad++;
                $display("FAIL credit: buffered+outstanding %0d exceeds %0d", occ, DP);
            end
            if (!instr_valid)
                check("idle_zero", {32'h0, instr, instr_pc, npc}, 128'h0);
            if (instr_valid && instr_ready && !flush) begin
                n_acc++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL word: got pc %0h expected nothing", instr_pc);
                end else begin
                    e = sb.pop_front();
                    check("word", {64'h0, instr, instr_pc}, {64'h0, e.instr, e.pc});
                    check("npc", {96'h0, npc}, {96'h0, e.npc});
                    if (instr_pc == 32'hFFFF_FFFC && npc == 32'h0) saw_wrap = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          k, snap, exp_drop;
        logic [95:0] hold;
        logic [31:0] a0, a1;

        rst = 1'b1; flush = 1'b0; flush_pc = '0; req_ready = 1'b0; instr_ready = 1'b0;
        tick(); tick(); tick();
        check("rst_req_valid", {127'h0, req_valid}, 128'h0);
        check("rst_instr_valid", {127'h0, instr_valid}, 128'h0);
        check("rst_outputs", {32'h0, instr, instr_pc, npc}, 128'h0);
        check("rst_req_addr", {96'h0, req_addr}, 128'h0);

        // ---- stream from reset, then stall on B ----
        sb_restart(32'h0);
        rst = 1'b0; req_ready = 1'b1; instr_ready = 1'b1;
        k = 0;
        while (!instr_valid && k < 50) begin tick(); k++; end
        check("first_latency", 128'(k), 128'd3);
        tick();
        instr_ready = 1'b0;
        check("stall_b", {64'h0, instr, instr_pc}, {64'h0, f_instr(32'h4), 32'h4});
        hold = {instr, instr_pc, npc};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hold", {32'h0, instr, instr_pc, npc}, {32'h0, hold});
        end
        for (int i = 0; i < 6; i++) tick();
        check("req_count", 128'(reqlog.size()), 128'd4);
        check("req_stop", {127'h0, req_valid}, 128'h0);
        a0 = (reqlog.size() == 4) ? reqlog[3] : 32'hBAD0_0000;
        check("req_addrs", {96'h0, a0}, {96'h0, 32'h30});
        snap = n_acc;
        instr_ready = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        check("no_bubbles", 128'(n_acc - snap), 128'd16);

        // ---- reset mid-stream with lines buffered ----
        instr_ready = 1'b0;
        k = 0;
        while (int'(dut.w_count) < 3 && k < 30) begin tick(); k++; end
        check("fill3", {127'h0, (int'(dut.w_count) >= 3)}, 128'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_restart(32'h0);
        #1;
        check("mid_rst_valid", {127'h0, instr_valid}, 128'h0);
        check("mid_rst_req", {95'h0, req_valid, req_addr}, {95'h0, 1'b1, 32'h0});
        instr_ready = 1'b1;
        snap = n_acc;
        for (int i = 0; i < 12; i++) tick();
        check("restart_flow", {127'h0, (n_acc - snap >= 6)}, 128'h1);

        // ---- flush to 0x48 with two requests outstanding ----
        rst = 1'b1; mem_lat = 4; instr_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        check("pre_flush_resp", {127'h0, resp_valid}, 128'h0);
        check("pre_flush_reqs", 128'(reqlog.size()), 128'd2);
        flush = 1'b1; flush_pc = 32'h48; instr_ready = 1'b1;
        sb_restart(32'h48);
        tick();
        flush = 1'b0;
        #1;
        check("flush_req", {95'h0, req_valid, req_addr}, {95'h0, 1'b1, 32'h40});
        check("flush_drop", 128'(dut.drop_cnt_q), 128'd2);
        snap = n_acc;
        for (int i = 0; i < 20; i++) tick();
        check("flush_flow", {127'h0, (n_acc - snap >= 10)}, 128'h1);
        mem_lat = 2;

        // ---- flush coinciding with a response and an accepted word ----
        k = 0;
        while (!(resp_valid && instr_valid) && k < 30) begin tick(); k++; end
        check("collide_found", {127'h0, (resp_valid && instr_valid)}, 128'h1);
        flush = 1'b1; flush_pc = 32'h100;
        exp_drop = mq.size();
        sb_restart(32'h100);
        tick();
        flush = 1'b0;
        #1;
        check("collide_drop", 128'(dut.drop_cnt_q), 128'(exp_drop));
        check("collide_empty", {127'h0, instr_valid}, 128'h0);
        snap = n_acc;
        for (int i = 0; i < 16; i++) tick();
        check("collide_flow", {127'h0, (n_acc - snap >= 8)}, 128'h1);

        // ---- address wrap ----
        flush = 1'b1; flush_pc = 32'hFFFF_FFF0;
        sb_restart(32'hFFFF_FFF0);
        reqlog.delete();
        tick();
        flush = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        a0 = (reqlog.size() > 0) ? reqlog[0] : 32'hBAD0_0001;
        a1 = (reqlog.size() > 1) ? reqlog[1] : 32'hBAD0_0002;
        check("wrap_req0", {96'h0, a0}, {96'h0, 32'hFFFF_FFF0});
        check("wrap_req1", {96'h0, a1}, 128'h0);
        check("wrap_npc", {127'h0, saw_wrap}, 128'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
